// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: push-button flag handshake plus countdown status bundle.
//   PB0_flag/PB1_flag : sticky event flags from the button-event block
//   PB0_read/PB1_read : one-cycle clear pulses back to the button-event block
//   count             : remaining seconds (CNT_W bits)
//   running/expired   : state decodes (RUN / DONE)
//   done_pulse        : one-cycle pulse on entry to DONE
// master = button-event / display side, slave = countdown_ctrl.
interface countdown_ctrl_if #(
  parameter int unsigned CNT_W = 7
);
  logic             PB0_flag;
  logic             PB1_flag;
  logic             PB0_read;
  logic             PB1_read;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             expired;
  logic             done_pulse;

  modport master (
    output PB0_flag, PB1_flag,
    input  PB0_read, PB1_read, count, running, expired, done_pulse
  );

  modport slave (
    input  PB0_flag, PB1_flag,
    output PB0_read, PB1_read, count, running, expired, done_pulse
  );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: seconds countdown driven by push-button event flags.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : countdown_ctrl_if.slave (flags in, read pulses and status out)
// PB0 = start/pause, PB1 = reload. A flag is consumed by returning a
// registered one-cycle read pulse; the pulse itself masks the flag for that
// cycle so one edge never yields two events.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | loaded with START_SEC, prescaler cleared, waiting for PB0
// ST_RUN   | prescaler counting, count decrements once per second
// ST_PAUSE | count and prescaler frozen (partial second kept)
// ST_DONE  | count reached 0, only PB1 (reload) leaves
module countdown_ctrl #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned START_SEC = 60,
  parameter int unsigned CNT_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  countdown_ctrl_if.slave    bus
);

  localparam int unsigned      PS_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0]  PS_MAX     = PS_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(START_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             pb0_read_q, pb0_read_d;
  logic             pb1_read_q, pb1_read_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             done_pulse_q, done_pulse_d;

  logic             acc0, acc1, tick;

  // A flag seen while its read pulse is high is the edge being cleared.
  assign acc0 = bus.PB0_flag & ~pb0_read_q;
  assign acc1 = bus.PB1_flag & ~pb1_read_q;
  assign tick = (state_q == ST_RUN) && (presc_q == PS_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= CNT_RELOAD;
      presc_q      <= '0;
      pb0_read_q   <= 1'b0;
      pb1_read_q   <= 1'b0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      pb0_read_q   <= pb0_read_d;
      pb1_read_q   <= pb1_read_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    pb0_read_d = acc0;
    pb1_read_d = acc1;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (acc0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          presc_d = '0;
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // The tick is applied first; a pause cannot pull us out of DONE.
        if (acc0 && (state_d == ST_RUN)) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (acc0) state_d = ST_RUN;
      end
      ST_DONE: begin
        presc_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reload overrides everything, including a same-cycle tick or PB0.
    if (acc1) begin
      state_d = ST_IDLE;
      count_d = CNT_RELOAD;
      presc_d = '0;
    end

    running_d    = (state_d == ST_RUN);
    expired_d    = (state_d == ST_DONE);
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  assign bus.PB0_read   = pb0_read_q;
  assign bus.PB1_read   = pb1_read_q;
  assign bus.count      = count_q;
  assign bus.running    = running_q;
  assign bus.expired    = expired_q;
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Consumer side of the push-button flag interface: samples the sticky PB0/PB1 event flags and returns a one-cycle read pulse to clear each flag.
- Drives a seconds countdown FSM from those events: PB0 = start/pause, PB1 = reload.
- Sits between the button-event block and the display/alarm logic.
- Outputs the current count, a run indicator, a sticky expired status and a one-cycle done pulse.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per one-second tick; must be >= 2.
- START_SEC, 60, reload value of the count; must be >= 1 and < 2**CNT_W.
- CNT_W, 7, width of the count output.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- PB0_flag  input  1  sticky start/pause event flag
- PB1_flag  input  1  sticky reload event flag
- PB0_read  output  1  registered one-cycle clear pulse for PB0_flag
- PB1_read  output  1  registered one-cycle clear pulse for PB1_flag
- count  output  CNT_W  remaining seconds, binary
- running  output  1  high in RUN
- expired  output  1  high in DONE
- done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst high at a clock edge) takes priority over everything and applies from any state, including mid-count. It sets:
  - state = IDLE, count = START_SEC, prescaler = 0
  - PB0_read = PB1_read = 0
  - running = expired = done_pulse = 0
- Flag consumption:
  - Flag x is "accepted" in cycle n when PBx_flag = 1 and PBx_read = 0 in that cycle.
  - On acceptance, PBx_read = 1 in cycle n+1 only.
  - In cycle n+1 the flag is still seen high, but PBx_read = 1 blocks re-acceptance.
  - If the flag is still 1 in cycle n+2 (a new edge arrived while it was being cleared), it is accepted again. Events are therefore never lost, and one edge never produces a double event.
- States and transitions (on accepted events):
  - IDLE: PB0 -> RUN.
  - RUN: PB0 -> PAUSE.
  - PAUSE: PB0 -> RUN.
  - DONE: PB0 is accepted and read-pulsed but ignored.
  - Any state: PB1 -> IDLE with count = START_SEC and prescaler = 0.
- Simultaneous PB0 and PB1 acceptance in the same cycle: both read pulses are issued, the PB1 action is taken, and PB0 is discarded.
- Prescaler:
  - Range 0..CLK_HZ-1; width is the ceiling of log2(CLK_HZ).
  - Increments only in RUN. Holds its value in PAUSE, so a partial second is kept. Cleared in IDLE, DONE and on reload.
- Tick: when prescaler = CLK_HZ-1 in RUN, prescaler wraps to 0.
  - If count > 1: count decrements by 1.
  - If count = 1: count goes to 0, state goes to DONE, and done_pulse = 1 for the next cycle only.
  - count never underflows and never leaves 0 except on reload or reset.
- Tick and PB0 in the same RUN cycle: the decrement (or DONE entry) is applied first.
  - If the tick causes DONE, the PB0 event is ignored.
  - Otherwise the state moves to PAUSE.
- Tick and PB1 in the same cycle: PB1 wins, no decrement, count = START_SEC.
- running and expired are registered decodes of the state (RUN and DONE respectively).
- Latency: an accepted event in cycle n changes state, running and expired at the edge ending cycle n.

Test Plan (CLK_HZ=4, START_SEC=3, CNT_W=7 unless noted):
- Reset then idle 20 cycles -> count=3, running=0, expired=0, no read pulses.
- PB0_flag held high until PB0_read is seen, then dropped one cycle later:
  - exactly one PB0_read pulse, one cycle after the flag was first seen high;
  - running=1;
  - count reads 2, 1, 0 at 4-cycle intervals;
  - done_pulse high for 1 cycle; expired=1; running=0.
- Start, then pause after 2 cycles of the first second:
  - count holds at 3 while paused;
  - on resume, the first decrement arrives 2 cycles after resume.
- PB0 and PB1 flags asserted in the same cycle while in RUN with count=2:
  - both reads pulse in the next cycle;
  - state IDLE, count=3, running=0.
- PB0_flag re-rises in the cycle its read pulse is high (new edge):
  - a second read pulse two cycles after the first;
  - state toggles twice (RUN then PAUSE).
- rst asserted mid-count with count=1 and PB1_flag pending:
  - at the next edge all outputs reach reset values;
  - the flag is accepted only after rst deasserts.
